alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command front-end for the ALU (arithmetic, logic, compare and shift units behind one result mux).
- Parses byte frames from the UART RX path into operands A/B and a 4-bit ALU_FUN.
- Issues a one-cycle ALU_EN and captures the ALU's registered result.
- Returns the result over the UART TX byte handshake, low byte first.
- Sits between the UART RX/TX synchronizer stages and the ALU top.

Parameters:
- WIDTH, 8, operand and byte width; ALU result is 2*WIDTH.
- TIMEOUT, 16, max cycles to wait for ALU_OUT_VLD after ALU_EN before aborting.
- OP_ALU_OPER, 8'hCC, command byte: A, B, FUN follow.
- OP_ALU_NOP, 8'hDD, command byte: FUN follows; reuse stored A, B.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- RX_P_DATA  in  WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid.
- ALU_OUT  in  2*WIDTH  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid (registered in ALU, ≥1 cycle after ALU_EN).
- TX_BUSY  in  1  TX cannot accept a byte.
- A  out  WIDTH  operand A register.
- B  out  WIDTH  operand B register.
- ALU_FUN  out  4  function select.
- ALU_EN  out  1  one-cycle ALU enable pulse.
- TX_P_DATA  out  WIDTH  byte to transmit.
- TX_D_VLD  out  1  TX_P_DATA valid; held until accepted.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Interface: one clock, CLK. Reset RST_n is asynchronous and active-low. All outputs are registered.
- Reset values: A, B, ALU_FUN, TX_P_DATA = 0; ALU_EN, TX_D_VLD, CMD_ERR = 0; state = IDLE; timeout counter = 0; result register = 0.
- States: IDLE, GET_A, GET_B, GET_FUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE:
  - RX_D_VLD with byte == OP_ALU_OPER -> GET_A.
  - Byte == OP_ALU_NOP -> GET_FUN.
  - Any other byte -> CMD_ERR pulse next cycle; stay IDLE.
- GET_A: on RX_D_VLD, A <= byte -> GET_B.
- GET_B: on RX_D_VLD, B <= byte -> GET_FUN.
- GET_FUN: on RX_D_VLD:
  - ALU_FUN <= byte[3:0]. Byte[7:4] must be 0; otherwise CMD_ERR pulse -> IDLE, A/B keep their new values.
  - Valid FUN: ALU_EN = 1 for exactly the next cycle; counter cleared -> ALU_WAIT.
- ALU_WAIT:
  - Counter increments each cycle.
  - ALU_OUT_VLD = 1 -> result <= ALU_OUT -> TX_LO. ALU_OUT_VLD takes priority if it coincides with counter == TIMEOUT-1.
  - Counter reaches TIMEOUT-1 without valid -> CMD_ERR pulse -> IDLE.
- TX_LO:
  - TX_P_DATA = result[WIDTH-1:0], TX_D_VLD = 1.
  - A transfer happens on a cycle with TX_D_VLD && !TX_BUSY.
  - Next cycle: TX_P_DATA = result[2W-1:W], TX_D_VLD stays 1, state TX_HI. No idle gap is required.
- TX_HI: on transfer, TX_D_VLD <= 0 -> IDLE.
- TX data stability: while TX_D_VLD = 1 and TX_BUSY = 1, TX_P_DATA and TX_D_VLD hold.
- RX bytes arriving in ALU_WAIT, TX_LO or TX_HI are dropped; CMD_ERR pulses (overrun); state unaffected.
- ALU_OUT_VLD outside ALU_WAIT is ignored.
- A and B persist across commands; ALU_FUN holds its last value.
- Reset asserted mid-frame or mid-TX returns everything to reset values immediately. No partial byte is re-sent.
- Throughput: one command in flight. Minimum frame-to-first-TX-byte latency is 3 cycles after the FUN byte, with a 1-cycle ALU.

Decomposition:
- Shared package holds:
  - opcode constants OP_ALU_OPER, OP_ALU_NOP;
  - the state enum encoding (3 bits);
  - ALU_FUN width constant 4.
- Optional sub-module alu_timeout_cnt: a clearable up-counter with a terminal flag at TIMEOUT-1. Everything else stays in the top FSM.

Test Plan:
- Send CC 0x0F 0x3C 0x04 with ALU returning 0x000C 1 cycle after ALU_EN -> A=0x0F, B=0x3C, FUN=4, ALU_EN single pulse; TX bytes 0x0C then 0x00; back to IDLE.
- Send DD 0x05 after the previous test -> A/B unchanged (0x0F/0x3C), FUN=5, one ALU_EN, two TX bytes.
- Send unknown byte 0x55 in IDLE -> single CMD_ERR pulse, no ALU_EN, no TX_D_VLD. Send CC 0x01 0x02 0x13 -> CMD_ERR on FUN, no ALU_EN.
- Hold ALU_OUT_VLD = 0 after ALU_EN with TIMEOUT = 16 -> CMD_ERR exactly 16 cycles after ALU_EN, no TX, IDLE accepts the next command.
- Result 0xABCD with TX_BUSY held high 5 cycles -> TX_P_DATA = 0xCD stable with TX_D_VLD = 1 throughout, transfer on the first !TX_BUSY cycle, then 0xAB. Inject an RX byte during TX -> CMD_ERR, TX sequence unaffected.
- Assert RST_n low while in GET_B and again while in TX_HI -> all outputs 0 asynchronously; the next complete frame works normally.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer.
//   OP_ALU_OPER : command byte followed by A, B and FUN bytes
//   OP_ALU_NOP  : command byte followed by a FUN byte only (A/B reused)
//   FUN_W       : width of the ALU function select
//   state_e     : sequencer FSM encoding
package alu_cmd_sequencer_pkg;

    localparam int         FUN_W       = 4;
    localparam logic [7:0] OP_ALU_OPER = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP  = 8'hDD;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_GET_FUN  = 3'd3,
        ST_ALU_WAIT = 3'd4,
        ST_TX_LO    = 3'd5,
        ST_TX_HI    = 3'd6
    } state_e;

endpackage

// File: rtl/alu_timeout_cnt.sv
// Watchdog for the ALU result wait.
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   clr_i   : synchronous clear to zero (wins over en_i)
//   en_i    : count up by one
//   tc_o    : count has reached TIMEOUT-1
module alu_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the ALU: parses UART RX frames into A/B/FUN,
// pulses ALU_EN, captures the result and returns it low byte first
// over the TX byte handshake.
//   CLK, RST_n               : clock, asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD      : received byte and its one-cycle strobe
//   ALU_OUT, ALU_OUT_VLD     : ALU result and its valid
//   TX_BUSY                  : TX cannot accept a byte
//   A, B, ALU_FUN, ALU_EN    : operands, function select, enable pulse
//   TX_P_DATA, TX_D_VLD      : byte to transmit, held until accepted
//   CMD_ERR                  : one-cycle error pulse
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_IDLE     | waiting for a command byte
// ST_GET_A    | waiting for operand A
// ST_GET_B    | waiting for operand B
// ST_GET_FUN  | waiting for the function byte
// ST_ALU_WAIT | ALU_EN issued, waiting for ALU_OUT_VLD or timeout
// ST_TX_LO    | offering result low byte
// ST_TX_HI    | offering result high byte
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic [WIDTH-1:0]   RX_P_DATA,
    input  logic               RX_D_VLD,
    input  logic [2*WIDTH-1:0] ALU_OUT,
    input  logic               ALU_OUT_VLD,
    input  logic               TX_BUSY,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [FUN_W-1:0]   ALU_FUN,
    output logic               ALU_EN,
    output logic [WIDTH-1:0]   TX_P_DATA,
    output logic               TX_D_VLD,
    output logic               CMD_ERR
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [FUN_W-1:0]   fun_q, fun_d;
    logic               alu_en_q, alu_en_d;
    logic [WIDTH-1:0]   tx_data_q, tx_data_d;
    logic               tx_vld_q, tx_vld_d;
    logic               err_q, err_d;
    // Only the upper result half needs storing: the lower half goes
    // straight into TX_P_DATA when the result is captured.
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;
    logic tx_xfer;

    alu_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk_i   (CLK),
        .rst_n_i (RST_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .tc_o    (cnt_tc)
    );

    assign tx_xfer = tx_vld_q && !TX_BUSY;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        fun_d     = fun_q;
        alu_en_d  = 1'b0;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        err_d     = 1'b0;
        res_hi_d  = res_hi_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WIDTH'(OP_ALU_OPER)) begin
                        state_d = ST_GET_A;
                    end else if (RX_P_DATA == WIDTH'(OP_ALU_NOP)) begin
                        state_d = ST_GET_FUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (RX_D_VLD) begin
                    a_d     = RX_P_DATA;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (RX_D_VLD) begin
                    b_d     = RX_P_DATA;
                    state_d = ST_GET_FUN;
                end
            end
            ST_GET_FUN: begin
                if (RX_D_VLD) begin
                    fun_d = RX_P_DATA[FUN_W-1:0];
                    if (RX_P_DATA[WIDTH-1:FUN_W] != '0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        alu_en_d = 1'b1;
                        cnt_clr  = 1'b1;
                        state_d  = ST_ALU_WAIT;
                    end
                end
            end
            ST_ALU_WAIT: begin
                cnt_en = 1'b1;
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
                // A result arriving on the terminal cycle still wins.
                if (ALU_OUT_VLD) begin
                    tx_data_d = ALU_OUT[WIDTH-1:0];
                    res_hi_d  = ALU_OUT[2*WIDTH-1:WIDTH];
                    tx_vld_d  = 1'b1;
                    state_d   = ST_TX_LO;
                end else if (cnt_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_TX_LO: begin
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
                if (tx_xfer) begin
                    tx_data_d = res_hi_q;
                    state_d   = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
                if (tx_xfer) begin
                    tx_vld_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            fun_q     <= '0;
            alu_en_q  <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            res_hi_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fun_q     <= fun_d;
            alu_en_q  <= alu_en_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
            res_hi_q  <= res_hi_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign ALU_FUN   = fun_q;
    assign ALU_EN    = alu_en_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        ALU_OUT_VLD = 1'b0;
    logic        TX_BUSY = 1'b0;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        CMD_ERR;

    alu_cmd_sequencer #(.WIDTH(8), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_n(RST_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Expected events, one queue per output kind.
    logic [19:0] en_q[$];   // {A, B, FUN} at each ALU_EN pulse
    logic [7:0]  tx_q[$];   // bytes in transfer order
    int          err_q[$];  // 0 = ordinary error, 1 = ALU timeout

    logic [7:0]  mA = 8'h00;
    logic [7:0]  mB = 8'h00;

    int          alu_lat = 1;      // 0 = ALU never answers
    logic        ovr_en = 1'b0;
    logic [15:0] ovr_val = 16'h0000;
    int          busy_mode = 0;    // 0 = busy_val, 1 = random
    logic        busy_val = 1'b0;

    function automatic logic [15:0] ref_alu(logic [7:0] a, logic [7:0] b, logic [3:0] f);
        logic [15:0] x;
        logic [15:0] y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (f)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x * y;
            4'd3:  return (b != 0) ? x / y : 16'h0000;
            4'd4:  return x & y;
            4'd5:  return x | y;
            4'd6:  return {8'h00, ~(a & b)};
            4'd7:  return {8'h00, ~(a | b)};
            4'd8:  return x ^ y;
            4'd9:  return {8'h00, ~(a ^ b)};
            4'd10: return (a == b) ? 16'd1 : 16'd0;
            4'd11: return (a > b) ? 16'd2 : 16'd0;
            4'd12: return (a < b) ? 16'd3 : 16'd0;
            4'd13: return x >> 1;
            4'd14: return x << 1;
            default: return {a, b};
        endcase
    endfunction

    // TX backpressure
    always @(posedge CLK) begin
        #2;
        TX_BUSY = (busy_mode != 0) ? ($urandom_range(0, 2) == 0) : busy_val;
    end

    // ALU: registered result alu_lat cycles after the ALU_EN cycle
    int          agent_lat;
    logic [15:0] agent_res;
    initial forever begin
        @(posedge CLK); #1;
        if (RST_n && ALU_EN && alu_lat > 0) begin
            agent_lat = alu_lat;
            agent_res = ovr_en ? ovr_val : ref_alu(A, B, ALU_FUN);
            repeat (agent_lat) @(posedge CLK);
            #1;
            ALU_OUT     = agent_res;
            ALU_OUT_VLD = 1'b1;
            @(posedge CLK); #1;
            ALU_OUT_VLD = 1'b0;
        end
    end

    // Monitor / scoreboard
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    int          cyc = 0;
    int          en_cyc = 0;
    logic [19:0] e_en;
    logic [7:0]  e_tx;
    int          e_err;
    initial forever begin
        @(negedge CLK);
        cyc++;
        if (!RST_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                vectors++;
                if (!(TX_D_VLD && TX_P_DATA == prev_data)) begin
                    miscompares++;
                    $display("FAIL tx_hold: got vld=%0b data=%02h, need vld=1 data=%02h",
                             TX_D_VLD, TX_P_DATA, prev_data);
                end
            end
            if (ALU_EN) begin
                en_cyc = cyc;
                vectors++;
                if (en_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL alu_en: got unexpected pulse A=%02h B=%02h FUN=%0h, need none", A, B, ALU_FUN);
                end else begin
                    e_en = en_q.pop_front();
                    if ({A, B, ALU_FUN} != e_en) begin
                        miscompares++;
                        $display("FAIL alu_en: got A=%02h B=%02h FUN=%0h, need A=%02h B=%02h FUN=%0h",
                                 A, B, ALU_FUN, e_en[19:12], e_en[11:4], e_en[3:0]);
                    end
                end
            end
            if (TX_D_VLD && !TX_BUSY) begin
                vectors++;
                if (tx_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL tx_byte: got unexpected byte %02h, need none", TX_P_DATA);
                end else begin
                    e_tx = tx_q.pop_front();
                    if (TX_P_DATA != e_tx) begin
                        miscompares++;
                        $display("FAIL tx_byte: got %02h, need %02h", TX_P_DATA, e_tx);
                    end
                end
            end
            if (CMD_ERR) begin
                vectors++;
                if (err_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL cmd_err: got unexpected pulse, need none");
                end else begin
                    e_err = err_q.pop_front();
                    if (e_err == 1) begin
                        vectors++;
                        if (cyc - en_cyc != TO) begin
                            miscompares++;
                            $display("FAIL timeout_delay: got %0d cycles after ALU_EN, need %0d",
                                     cyc - en_cyc, TO);
                        end
                    end
                end
            end
            prev_hold = TX_D_VLD && TX_BUSY;
            prev_data = TX_P_DATA;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick(1);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic send_fun(logic [7:0] f, int lat, bit inject);
        logic [15:0] r;
        bit          timed_out;
        alu_lat = lat;
        if (f[7:4] != 4'h0) begin
            err_q.push_back(0);
            send_byte(f);
        end else begin
            timed_out = !(lat >= 1 && lat <= TO - 1);
            r = ovr_en ? ovr_val : ref_alu(mA, mB, f[3:0]);
            en_q.push_back({mA, mB, f[3:0]});
            if (!timed_out) begin
                tx_q.push_back(r[7:0]);
                tx_q.push_back(r[15:8]);
            end
            send_byte(f);
            if (inject) begin
                err_q.push_back(0);
                send_byte(8'($urandom));
            end
            if (timed_out) err_q.push_back(1);
        end
    endtask

    task automatic cmd_oper(logic [7:0] a, logic [7:0] b, logic [7:0] f, int lat, bit inject, int gap);
        send_byte(8'hCC);
        tick(gap);
        send_byte(a);
        mA = a;
        tick(gap);
        send_byte(b);
        mB = b;
        tick(gap);
        send_fun(f, lat, inject);
    endtask

    task automatic cmd_nop(logic [7:0] f, int lat, bit inject);
        send_byte(8'hDD);
        send_fun(f, lat, inject);
    endtask

    task automatic drain();
        int i;
        int pend;
        i = 0;
        pend = en_q.size() + tx_q.size() + err_q.size();
        while (i < 400 && pend != 0) begin
            tick(1);
            i++;
            pend = en_q.size() + tx_q.size() + err_q.size();
        end
        vectors++;
        if (pend != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d expected events still pending after %0d cycles, need 0", pend, i);
            en_q.delete();
            tx_q.delete();
            err_q.delete();
        end
        tick(22);
    endtask

    task automatic check_zero(string name);
        vectors++;
        if ({A, B, ALU_FUN, TX_P_DATA, ALU_EN, TX_D_VLD, CMD_ERR} !== 39'd0) begin
            miscompares++;
            $display("FAIL %s: got A=%02h B=%02h FUN=%0h TXD=%02h EN=%0b VLD=%0b ERR=%0b, need all 0",
                     name, A, B, ALU_FUN, TX_P_DATA, ALU_EN, TX_D_VLD, CMD_ERR);
        end
    endtask

    task automatic wait_tx_vld(string name);
        int i;
        i = 0;
        while (i < 60 && !TX_D_VLD) begin
            tick(1);
            i++;
        end
        vectors++;
        if (!TX_D_VLD) begin
            miscompares++;
            $display("FAIL %s: got TX_D_VLD=0 after %0d cycles, need 1", name, i);
        end
    endtask

    task automatic model_reset();
        en_q.delete();
        tx_q.delete();
        err_q.delete();
        mA = 8'h00;
        mB = 8'h00;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] f;
        int kind;
        int lat;

        RST_n = 1'b0;
        tick(3);
        check_zero("reset_state");
        RST_n = 1'b1;
        tick(2);

        // OPER frame, AND, 1-cycle ALU, minimum latency
        send_byte(8'hCC);
        send_byte(8'h0F);
        mA = 8'h0F;
        send_byte(8'h3C);
        mB = 8'h3C;
        send_fun(8'h04, 1, 1'b0);
        tick(1);
        vectors++;
        if (TX_D_VLD !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got TX_D_VLD=%0b two cycles after FUN, need 0", TX_D_VLD);
        end
        tick(1);
        vectors++;
        if (!(TX_D_VLD === 1'b1 && TX_P_DATA == 8'h0C)) begin
            miscompares++;
            $display("FAIL latency: got vld=%0b data=%02h three cycles after FUN, need vld=1 data=0c",
                     TX_D_VLD, TX_P_DATA);
        end
        drain();

        // NOP frame reuses A/B
        cmd_nop(8'h05, 1, 1'b0);
        drain();

        // unknown command byte, then bad FUN nibble
        err_q.push_back(0);
        send_byte(8'h55);
        drain();
        cmd_oper(8'h01, 8'h02, 8'h13, 1, 1'b0, 0);
        drain();

        // timeout and the boundary either side of it
        cmd_oper(8'h07, 8'h08, 8'h00, 0, 1'b0, 0);
        drain();
        cmd_nop(8'h08, 2, 1'b0);
        drain();
        cmd_nop(8'h04, TO - 1, 1'b0);
        drain();
        cmd_nop(8'h02, TO, 1'b0);
        drain();

        // held TX with an overrun byte in the middle
        ovr_en  = 1'b1;
        ovr_val = 16'hABCD;
        busy_val = 1'b1;
        cmd_oper(8'h12, 8'h34, 8'h02, 1, 1'b0, 1);
        wait_tx_vld("busy_tx_start");
        tick(2);
        err_q.push_back(0);
        send_byte(8'h5A);
        tick(2);
        busy_val = 1'b0;
        drain();
        ovr_en = 1'b0;

        // reset while in GET_B
        send_byte(8'hCC);
        send_byte(8'h01);
        RST_n = 1'b0;
        #1;
        check_zero("reset_in_get_b");
        model_reset();
        tick(2);
        RST_n = 1'b1;
        tick(1);
        cmd_oper(8'h21, 8'h43, 8'h00, 1, 1'b0, 0);
        drain();

        // reset while in TX_HI
        busy_val = 1'b1;
        cmd_oper(8'h33, 8'h22, 8'h04, 1, 1'b0, 0);
        wait_tx_vld("tx_hi_start");
        busy_val = 1'b0;
        tick(1);
        busy_val = 1'b1;
        tick(1);
        RST_n = 1'b0;
        #1;
        check_zero("reset_in_tx_hi");
        model_reset();
        tick(2);
        RST_n = 1'b1;
        busy_val = 1'b0;
        tick(1);
        cmd_oper(8'h5E, 8'h03, 8'h01, 1, 1'b0, 0);
        drain();

        // randomized traffic with random backpressure
        busy_mode = 1;
        for (int n = 0; n < 50; n++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 8) lat = $urandom_range(1, 4);
            else if ($urandom_range(0, 1) == 0) lat = $urandom_range(TO - 2, TO);
            else lat = $urandom_range(TO + 1, TO + 4);
            if ($urandom_range(0, 99) < 85) f = {4'h0, 4'($urandom)};
            else f = {4'($urandom_range(1, 15)), 4'($urandom)};
            if (kind == 0) begin
                b = 8'($urandom);
                if (b == 8'hCC || b == 8'hDD) b = 8'h00;
                err_q.push_back(0);
                send_byte(b);
            end else if (kind <= 2) begin
                cmd_nop(f, lat, ($urandom_range(0, 4) == 0) && f[7:4] == 4'h0);
            end else begin
                cmd_oper(8'($urandom), 8'($urandom), f, lat,
                         ($urandom_range(0, 4) == 0) && f[7:4] == 4'h0, $urandom_range(0, 2));
            end
            drain();
        end
        busy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
